// File: rtl/reprogram_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter, with a running XOR of every
// byte whose stop bit has completed.
module reprogram_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk_50mhz,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          clr_xorc,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [7:0]                    xorc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt, bit_cnt_nxt, bit_inc;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic          tx_nxt, push, pop, frame_done, fifo_empty;

  assign fifo_empty = (count == '0);
  assign in_ready   = (count != FULL);
  assign push       = in_valid && in_ready;
  assign busy       = !fifo_empty || (state != IDLE);
  assign bit_inc    = bit_cnt + 3'd1;

  always_comb begin
    state_nxt   = state;
    tx_nxt      = tx;
    bit_cnt_nxt = bit_cnt;
    clk_cnt_nxt = clk_cnt + CW'(1);
    pop         = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt      = 1'b1;
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (clk_cnt == CLK_LAST) begin
          clk_cnt_nxt = '0;
          tx_nxt      = shift[0];
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (clk_cnt == CLK_LAST) begin
          clk_cnt_nxt = '0;
          if (bit_cnt == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            bit_cnt_nxt = bit_inc;
            tx_nxt      = shift[bit_inc];
          end
        end
      end
      STOP: begin
        if (clk_cnt == CLK_LAST) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          frame_done  = 1'b1;
          // back-to-back frames: pop straight into START with no idle gap
          if (!fifo_empty) begin
            pop       = 1'b1;
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      clk_cnt <= '0;
      shift   <= '0;
      xorc    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      tx      <= tx_nxt;
      bit_cnt <= bit_cnt_nxt;
      clk_cnt <= clk_cnt_nxt;
      if (pop) begin
        shift  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // clear takes priority, then the completed byte is folded in
      if (clr_xorc) xorc <= frame_done ? shift : '0;
      else if (frame_done) xorc <= xorc ^ shift;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule
